// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the fetch stage.
//   - Instruction field widths: opcode in the top OPCODE_W bits, operand below.
//   - Opcode constants used by fetch and the rest of the pipeline.
//   - is_delay_nop(): identifies a NOP that carries a non-zero delay operand.
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

  localparam int OPCODE_W  = 4;
  localparam int OPERAND_W = 24;

  // Opcode map shared across pipeline stages
  localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_AND = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_OR  = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_LD  = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_ST  = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_BEQ = 4'h8;

  // A NOP with operand N > 0 stalls fetch for N bubble cycles; N = 0 is a plain NOP.
  function automatic logic is_delay_nop(input logic [OPCODE_W-1:0]  opcode,
                                        input logic [OPERAND_W-1:0] operand);
    return (opcode == OP_NOP) && (operand != {OPERAND_W{1'b0}});
  endfunction

endpackage

// File: rtl/fetch_delay_counter.sv
// -----------------------------------------------------------------------------
// fetch_delay_counter
// Loadable down-counter that times the bubble cycles following a delay NOP.
// Ports:
//   clk_i      - clock, rising edge
//   rst_i      - synchronous active-high reset, clears the count
//   clear_i    - synchronous clear (branch redirect), beats load and enable
//   load_i     - load load_val_i into the count
//   load_val_i - delay length N
//   en_i       - decrement by one (saturates at zero)
//   done_o     - high while the count is 1, i.e. the final bubble cycle
// -----------------------------------------------------------------------------
module fetch_delay_counter
  import instruction_fetch_pkg::*;
#(
  parameter int CNT_W = OPERAND_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear > load > decrement; never wraps below zero
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = CNT_ZERO;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != CNT_ZERO)) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CNT_ONE);

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage: drives a combinational program ROM from the PC and registers the
// returned word toward decode. Handles stall, branch redirect and NOP-encoded
// delays (a NOP with operand N inserts N bubbles after it).
// Ports:
//   Clock         - sole clock, rising edge
//   Reset         - synchronous active-high reset
//   oAddress      - ROM address, the current PC (combinational)
//   iInstruction  - ROM data for oAddress, same cycle
//   iStall        - decode hold request: all fetch state holds
//   iBranchTaken  - redirect request, overrides stall
//   iBranchTarget - redirect address
//   oInstruction  - registered instruction (bubble word when oValid = 0)
//   oPC           - address oInstruction was fetched from
//   oValid        - oInstruction is real (0 = bubble)
// -----------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                 ADDR_W     = 16,
  parameter int                 INSTR_W    = 28,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = 16'd0
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  oAddress,
  input  logic [INSTR_W-1:0] iInstruction,
  input  logic               iStall,
  input  logic               iBranchTaken,
  input  logic [ADDR_W-1:0]  iBranchTarget,
  output logic [INSTR_W-1:0] oInstruction,
  output logic [ADDR_W-1:0]  oPC,
  output logic               oValid
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DELAY = 1'b1
  } state_e;

  localparam logic [INSTR_W-1:0] BUBBLE   = {OP_NOP, {(INSTR_W-OPCODE_W){1'b0}}};
  localparam logic [ADDR_W-1:0]  ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  opc_q, opc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;

  logic [OPCODE_W-1:0]  opcode_s;
  logic [OPERAND_W-1:0] operand_s;
  logic                 cnt_clear_s;
  logic                 cnt_load_s;
  logic                 cnt_en_s;
  logic                 cnt_done_s;

  assign opcode_s  = iInstruction[INSTR_W-1 -: OPCODE_W];
  assign operand_s = iInstruction[OPERAND_W-1:0];

  fetch_delay_counter #(
    .CNT_W (OPERAND_W)
  ) u_dcnt (
    .clk_i      (Clock),
    .rst_i      (Reset),
    .clear_i    (cnt_clear_s),
    .load_i     (cnt_load_s),
    .load_val_i (operand_s),
    .en_i       (cnt_en_s),
    .done_o     (cnt_done_s)
  );

  // Next-state: branch > stall > delay countdown / sequential fetch
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    opc_d       = opc_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    cnt_clear_s = 1'b0;
    cnt_load_s  = 1'b0;
    cnt_en_s    = 1'b0;
    if (iBranchTaken) begin
      // oPC keeps its last value; the bubble is marked by oValid = 0
      pc_d        = iBranchTarget;
      valid_d     = 1'b0;
      instr_d     = BUBBLE;
      state_d     = FETCH;
      cnt_clear_s = 1'b1;
    end else if (iStall) begin
      state_d = state_q;
    end else begin
      case (state_q)
        FETCH: begin
          instr_d = iInstruction;
          opc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + ADDR_ONE;
          if (is_delay_nop(opcode_s, operand_s)) begin
            cnt_load_s = 1'b1;
            state_d    = DELAY;
          end else begin
            state_d    = FETCH;
          end
        end
        DELAY: begin
          // PC already points past the NOP; just hold it while bubbling
          valid_d  = 1'b0;
          instr_d  = BUBBLE;
          cnt_en_s = 1'b1;
          if (cnt_done_s) begin
            state_d = FETCH;
          end else begin
            state_d = DELAY;
          end
        end
        default: begin
          state_d = FETCH;
          valid_d = 1'b0;
          instr_d = BUBBLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_ADDR;
      opc_q   <= {ADDR_W{1'b0}};
      instr_q <= BUBBLE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      opc_q   <= opc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign oAddress     = pc_q;
  assign oInstruction = instr_q;
  assign oPC          = opc_q;
  assign oValid       = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch with a behavioural combinational ROM.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 28;
  localparam logic [INSTR_W-1:0] BUBBLE_W = {OP_NOP, 24'd0};

  logic               Clock;
  logic               Reset;
  logic [ADDR_W-1:0]  oAddress;
  logic [INSTR_W-1:0] iInstruction;
  logic               iStall;
  logic               iBranchTaken;
  logic [ADDR_W-1:0]  iBranchTarget;
  logic [INSTR_W-1:0] oInstruction;
  logic [ADDR_W-1:0]  oPC;
  logic               oValid;

  logic [INSTR_W-1:0] rom [0:65535];

  int n_checks;
  int n_fail;

  instruction_fetch #(
    .ADDR_W     (ADDR_W),
    .INSTR_W    (INSTR_W),
    .RESET_ADDR (16'd0)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .oAddress      (oAddress),
    .iInstruction  (iInstruction),
    .iStall        (iStall),
    .iBranchTaken  (iBranchTaken),
    .iBranchTarget (iBranchTarget),
    .oInstruction  (oInstruction),
    .oPC           (oPC),
    .oValid        (oValid)
  );

  assign iInstruction = rom[oAddress];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare the three decode-facing outputs in one call
  task automatic expect_out(input string tag, input logic v, input logic [15:0] pc,
                            input logic [27:0] ins);
    check_eq({tag, ".valid"}, {31'd0, oValid}, {31'd0, v});
    check_eq({tag, ".pc"},    {16'd0, oPC},    {16'd0, pc});
    check_eq({tag, ".instr"}, {4'd0, oInstruction}, {4'd0, ins});
  endtask

  task automatic expect_bubble(input string tag, input logic [15:0] addr);
    check_eq({tag, ".valid"}, {31'd0, oValid}, 32'd0);
    check_eq({tag, ".instr"}, {4'd0, oInstruction}, {4'd0, BUBBLE_W});
    check_eq({tag, ".addr"},  {16'd0, oAddress}, {16'd0, addr});
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    Reset         = 1'b1;
    iStall        = 1'b0;
    iBranchTaken  = 1'b0;
    iBranchTarget = 16'd0;
    for (int i = 0; i < 65536; i++) begin
      rom[i] = {OP_ADD, 8'h00, i[15:0]};
    end

    // Reset state
    tick();
    tick();
    expect_out("rst", 1'b0, 16'd0, BUBBLE_W);
    check_eq("rst.addr", {16'd0, oAddress}, 32'd0);

    // Sequential fetch: first Reset=0 edge captures ROM[0]
    Reset = 1'b0;
    tick(); expect_out("seq0", 1'b1, 16'd0, {OP_ADD, 24'd0});
    tick(); expect_out("seq1", 1'b1, 16'd1, {OP_ADD, 24'd1});
    tick(); expect_out("seq2", 1'b1, 16'd2, {OP_ADD, 24'd2});
    tick(); expect_out("seq3", 1'b1, 16'd3, {OP_ADD, 24'd3});

    // NOP delay of 3, with a stall in the middle of the bubbles
    rom[1] = {OP_NOP, 24'd3};
    rom[7] = {OP_NOP, 24'd0};
    rom[9] = {OP_NOP, 24'd5};
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick(); expect_out("nop.pc0", 1'b1, 16'd0, {OP_ADD, 24'd0});
    tick(); expect_out("nop.pc1", 1'b1, 16'd1, {OP_NOP, 24'd3});
    tick(); expect_bubble("nop.b1", 16'd2);
    iStall = 1'b1;
    tick(); expect_bubble("nop.bstall", 16'd2);
    iStall = 1'b0;
    tick(); expect_bubble("nop.b2", 16'd2);
    tick(); expect_bubble("nop.b3", 16'd2);
    tick(); expect_out("nop.pc2", 1'b1, 16'd2, {OP_ADD, 24'd2});
    tick(); expect_out("run.pc3", 1'b1, 16'd3, {OP_ADD, 24'd3});
    tick(); expect_out("run.pc4", 1'b1, 16'd4, {OP_ADD, 24'd4});
    tick(); expect_out("run.pc5", 1'b1, 16'd5, {OP_ADD, 24'd5});

    // Two stall cycles at oPC=5
    iStall = 1'b1;
    tick(); expect_out("stall1", 1'b1, 16'd5, {OP_ADD, 24'd5});
    tick(); expect_out("stall2", 1'b1, 16'd5, {OP_ADD, 24'd5});
    iStall = 1'b0;
    tick(); expect_out("stall.pc6", 1'b1, 16'd6, {OP_ADD, 24'd6});

    // NOP with zero operand is a single ordinary instruction
    tick(); expect_out("nop0.pc7", 1'b1, 16'd7, {OP_NOP, 24'd0});
    tick(); expect_out("nop0.pc8", 1'b1, 16'd8, {OP_ADD, 24'd8});

    // Branch wins over a simultaneous stall
    iBranchTaken = 1'b1; iBranchTarget = 16'd6; iStall = 1'b1;
    tick(); expect_bubble("brst", 16'd6);
    iBranchTaken = 1'b0; iStall = 1'b0;
    tick(); expect_out("brst.pc6", 1'b1, 16'd6, {OP_ADD, 24'd6});

    // Branch to the current PC refetches it
    iBranchTaken = 1'b1; iBranchTarget = 16'd7;
    tick(); expect_bubble("self", 16'd7);
    iBranchTaken = 1'b0;
    tick(); expect_out("self.pc7", 1'b1, 16'd7, {OP_NOP, 24'd0});

    // Branch during a delay aborts the rest of the delay
    tick(); expect_out("abort.pc8", 1'b1, 16'd8, {OP_ADD, 24'd8});
    tick(); expect_out("abort.pc9", 1'b1, 16'd9, {OP_NOP, 24'd5});
    tick(); expect_bubble("abort.b1", 16'd10);
    iBranchTaken = 1'b1; iBranchTarget = 16'd20;
    tick(); expect_bubble("abort.br", 16'd20);
    iBranchTaken = 1'b0;
    tick(); expect_out("abort.pc20", 1'b1, 16'd20, {OP_ADD, 24'd20});
    tick(); expect_out("abort.pc21", 1'b1, 16'd21, {OP_ADD, 24'd21});

    // PC wraps from FFFF to 0000
    iBranchTaken = 1'b1; iBranchTarget = 16'hFFFF;
    tick(); expect_bubble("wrap.br", 16'hFFFF);
    iBranchTaken = 1'b0;
    tick(); expect_out("wrap.ffff", 1'b1, 16'hFFFF, {OP_ADD, 8'h00, 16'hFFFF});
    check_eq("wrap.addr", {16'd0, oAddress}, 32'd0);
    tick(); expect_out("wrap.0000", 1'b1, 16'd0, {OP_ADD, 24'd0});

    // Reset (with stall and branch also high) during a long delay
    rom[1] = {OP_NOP, 24'd4000};
    tick(); expect_out("rdly.pc1", 1'b1, 16'd1, {OP_NOP, 24'd4000});
    tick(); expect_bubble("rdly.b1", 16'd2);
    tick(); expect_bubble("rdly.b2", 16'd2);
    Reset = 1'b1; iStall = 1'b1; iBranchTaken = 1'b1; iBranchTarget = 16'd30;
    tick(); expect_out("rdly.rst", 1'b0, 16'd0, BUBBLE_W);
    check_eq("rdly.addr", {16'd0, oAddress}, 32'd0);
    Reset = 1'b0; iStall = 1'b0; iBranchTaken = 1'b0;
    tick(); expect_out("rdly.pc0", 1'b1, 16'd0, {OP_ADD, 24'd0});
    tick(); expect_out("rdly.pc1b", 1'b1, 16'd1, {OP_NOP, 24'd4000});
    tick(); expect_bubble("rdly.b1b", 16'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
